// File: rtl/mod_add_vec_ctrl.sv
// rtl/mod_add_vec_ctrl.sv - sequencer for element-wise modular vector addition
// Issues operand reads, feeds the 2-cycle ModAdd datapath and writes results back delay-matched.
module mod_add_vec_ctrl #(
   parameter int K      = 54,
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   n_len,
   input  logic [K-1:0]      q_in,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [K-1:0]      rd_data_a,
   input  logic [K-1:0]      rd_data_b,
   output logic [K-1:0]      add_ina,
   output logic [K-1:0]      add_inb,
   output logic [K-1:0]      add_q,
   input  logic [K-1:0]      add_out,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [K-1:0]      wr_data
);

   localparam int D = RD_LAT + 2;
   localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                       state_q, state_d;
   logic [ADDR_W:0]              cnt_q, cnt_d;
   logic [ADDR_W:0]              n_q, n_d;
   logic [K-1:0]                 q_q, q_d;
   logic [D-1:0]                 vld_q, vld_d;
   logic [D-1:0][ADDR_W-1:0]     addr_q, addr_d;
   logic                         issue;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      q_d     = q_q;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (n_len != '0) begin
                  state_d = S_RUN;
                  n_d     = n_len;
                  q_d     = q_in;
                  cnt_d   = '0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RUN: begin
            if (!hold) begin
               issue = 1'b1;
               cnt_d = cnt_q + ONE;
               // counter is one bit wider than the address, so n = 2**ADDR_W ends cleanly
               if (cnt_q == n_q - ONE) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // only the final stage may still be occupied: that write happens this cycle
            if (vld_q[D-2:0] == '0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      vld_d  = {vld_q[D-2:0], issue};
      addr_d = {addr_q[D-2:0], cnt_q[ADDR_W-1:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         n_q     <= '0;
         q_q     <= '0;
         vld_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         q_q     <= q_d;
         vld_q   <= vld_d;
         addr_q  <= addr_d;
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign rd_en   = issue;
   assign rd_addr = cnt_q[ADDR_W-1:0];
   assign add_ina = rd_data_a;
   assign add_inb = rd_data_b;
   assign add_q   = q_q;
   assign wr_en   = vld_q[D-1];
   assign wr_addr = addr_q[D-1];
   assign wr_data = add_out;

endmodule
